// File: rtl/sprite_line_fetch_pkg.sv
// sprite_line_fetch_pkg: shared sizes, fetch FSM states and ROM address helper
//   SPR_W / SPR_H : default sprite size in pixels / lines
//   ROM_AW        : sprite ROM address width
//   PIX_W         : palette-index width
package sprite_line_fetch_pkg;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 32;
    localparam int ROM_AW = 15;
    localparam int PIX_W  = 4;

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} fetch_state_t;

    // Each frame owns a 1024-entry slot; rows are laid out w entries apart.
    function automatic logic [ROM_AW-1:0] rom_base(input logic [4:0] frame,
                                                   input logic [ROM_AW-1:0] row,
                                                   input logic [ROM_AW-1:0] w);
        return {frame, 10'd0} + row * w;
    endfunction
endpackage

// File: rtl/sprite_line_buf.sv
// sprite_line_buf: ping-pong pair of SPR_W x PIX_W line buffers
//   clk, rst_n            : clock, async active-low reset (select and valid flags only)
//   swap                  : exchange fetch and display roles, invalidating the new fetch side
//   wr_en/wr_addr/wr_data : write port into the fetch buffer
//   set_valid, clr_valid  : mark the fetch buffer complete / empty
//   rd_addr/rd_data       : combinational read of the display buffer
//   rd_valid              : display buffer holds a complete line
module sprite_line_buf
    import sprite_line_fetch_pkg::*;
#(
    parameter int SPR_W = sprite_line_fetch_pkg::SPR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     swap,
    input  logic                     wr_en,
    input  logic [$clog2(SPR_W)-1:0] wr_addr,
    input  logic [PIX_W-1:0]         wr_data,
    input  logic                     set_valid,
    input  logic                     clr_valid,
    input  logic [$clog2(SPR_W)-1:0] rd_addr,
    output logic [PIX_W-1:0]         rd_data,
    output logic                     rd_valid
);
    logic [PIX_W-1:0] mem [2][SPR_W];
    logic             sel;
    logic [1:0]       vld;

    // sel names the display buffer; the fetch buffer is always ~sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
            vld <= 2'b00;
        end else if (swap) begin
            sel      <= ~sel;
            vld[sel] <= 1'b0;
        end else if (set_valid) begin
            vld[~sel] <= 1'b1;
        end else if (clr_valid) begin
            vld[~sel] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[~sel][wr_addr] <= wr_data;
    end

    assign rd_data  = mem[sel][rd_addr];
    assign rd_valid = vld[sel];
endmodule

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: per-line sprite ROM fetch into a line buffer and pixel output
//   Clk, Reset_n          : clock, async active-low reset
//   frame_start           : latch Sprite_X/Sprite_Y/Frame/Enable descriptor
//   line_start, Next_Y    : request fetch of screen line Next_Y, swap line buffers
//   DrawX                 : current display column
//   rom_addr, rom_data    : synchronous sprite ROM port (data 1 cycle after address)
//   pixel_idx/pixel_valid : registered palette index for DrawX and its opacity
//   busy, overrun         : fetch in progress / sticky aborted-fetch flag
module sprite_line_fetch
    import sprite_line_fetch_pkg::*;
#(
    parameter int SPR_W = sprite_line_fetch_pkg::SPR_W,
    parameter int SPR_H = sprite_line_fetch_pkg::SPR_H
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [9:0]        Next_Y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        Sprite_X,
    input  logic [9:0]        Sprite_Y,
    input  logic [4:0]        Frame,
    input  logic              Enable,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  pixel_idx,
    output logic              pixel_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int            CW   = $clog2(SPR_W);
    localparam logic [CW-1:0] LAST = CW'(SPR_W - 1);

    fetch_state_t     state;
    logic [9:0]       x_lat, y_lat, ny_lat;
    logic [4:0]       frame_lat;
    logic             en_lat;
    logic [CW-1:0]    col, wr_addr;
    logic [10:0]      row, dx;
    logic             hit, wr_en, set_valid, clr_valid, on, rd_valid;
    logic [PIX_W-1:0] rd_data, pix;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_lat     <= '0;
            y_lat     <= '0;
            frame_lat <= '0;
            en_lat    <= 1'b0;
        end else if (frame_start) begin
            x_lat     <= Sprite_X;
            y_lat     <= Sprite_Y;
            frame_lat <= Frame;
            en_lat    <= Enable;
        end
    end

    // 11-bit differences keep "below the sprite" from aliasing into range,
    // which also clips sprites running past column/line 1023.
    // A line_start in the same cycle takes priority over any buffer update.
    always_comb begin
        row       = {1'b0, ny_lat} - {1'b0, y_lat};
        hit       = en_lat && ny_lat >= y_lat && row < 11'(SPR_H);
        wr_en     = !line_start && ((state == FETCH && col != '0) || state == DRAIN);
        wr_addr   = (state == DRAIN) ? LAST : col - 1'b1;
        set_valid = !line_start && state == DRAIN;
        clr_valid = !line_start && state == CHECK && !hit;
        dx        = {1'b0, DrawX} - {1'b0, x_lat};
        on        = rd_valid && DrawX >= x_lat && dx < 11'(SPR_W);
        pix       = on ? rd_data : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            rom_addr <= '0;
            col      <= '0;
            ny_lat   <= '0;
        end else if (line_start) begin
            ny_lat <= Next_Y;
            state  <= CHECK;
            busy   <= 1'b1;
            if (state == FETCH || state == DRAIN) overrun <= 1'b1;
        end else begin
            case (state)
                CHECK: begin
                    if (hit) begin
                        state    <= FETCH;
                        col      <= '0;
                        rom_addr <= rom_base(frame_lat, ROM_AW'(row), ROM_AW'(SPR_W));
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FETCH: begin
                    col <= col + 1'b1;
                    if (col == LAST) begin
                        state <= DRAIN;
                        busy  <= 1'b0;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_idx   <= pix;
            pixel_valid <= |pix;
        end
    end

    sprite_line_buf #(.SPR_W(SPR_W)) u_buf (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .swap      (line_start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (rom_data),
        .set_valid (set_valid),
        .clr_valid (clr_valid),
        .rd_addr   (dx[CW-1:0]),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );
endmodule

// File: tb/tb_sprite_line_fetch.sv
// tb_sprite_line_fetch: directed self-checking bench for sprite_line_fetch
module tb_sprite_line_fetch;
    logic        Clk = 1'b0, Reset_n = 1'b1, frame_start = 1'b0, line_start = 1'b0;
    logic [9:0]  Next_Y = '0, DrawX = '0, Sprite_X = '0, Sprite_Y = '0;
    logic [4:0]  Frame = '0;
    logic        Enable = 1'b0;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data, pixel_idx;
    logic        pixel_valid, busy, overrun;
    logic [3:0]  rom [32768];
    int          checks = 0, fails = 0;

    sprite_line_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .line_start(line_start),
        .Next_Y(Next_Y), .DrawX(DrawX), .Sprite_X(Sprite_X), .Sprite_Y(Sprite_Y),
        .Frame(Frame), .Enable(Enable), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_idx(pixel_idx), .pixel_valid(pixel_valid), .busy(busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[rom_addr];

    function automatic logic [3:0] pat(input int a);
        if (a == 3237) return 4'hA;
        if (a == 3238) return 4'h0;
        return 4'((a * 7) % 15 + 1);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_desc(input int x, input int y, input int f, input logic en);
        Sprite_X = 10'(x);
        Sprite_Y = 10'(y);
        Frame = 5'(f);
        Enable = en;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input int ny);
        Next_Y = 10'(ny);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic draw(input int x);
        DrawX = 10'(x);
        tick();
    endtask

    task automatic count_valid(input int lo, input int hi, output int n);
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            draw(i);
            n += int'(pixel_valid);
        end
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        #2;
        checks += 5;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        if (pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_pixel_valid got %b want 0", pixel_valid); end
        if (pixel_idx !== 4'h0) begin fails++; $display("FAIL reset_pixel_idx got %h want 0", pixel_idx); end
        if (rom_addr !== 15'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        set_desc(100, 200, 3, 1'b1);
        pulse_line(205);
        checks += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL hit_busy_check got %b want 1", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL hit_overrun got %b want 0", overrun); end
        for (int i = 0; i < 32; i++) begin
            tick();
            checks += 2;
            if (rom_addr !== 15'(3232 + i)) begin fails++; $display("FAIL hit_rom_addr[%0d] got %0d want %0d", i, rom_addr, 3232 + i); end
            if (busy !== 1'b1) begin fails++; $display("FAIL hit_busy_fetch[%0d] got %b want 1", i, busy); end
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL hit_busy_drain got %b want 0", busy); end
        tick();
        tick();
        checks++;
        if (rom_addr !== 15'd3263) begin fails++; $display("FAIL hit_rom_addr_hold got %0d want 3263", rom_addr); end
    endtask

    task automatic test_display();
        pulse_line(300);
        tick();
        tick();
        draw(105);
        checks += 2;
        if (pixel_idx !== 4'hA) begin fails++; $display("FAIL disp_105_idx got %h want a", pixel_idx); end
        if (pixel_valid !== 1'b1) begin fails++; $display("FAIL disp_105_valid got %b want 1", pixel_valid); end
        draw(106);
        checks += 2;
        if (pixel_idx !== 4'h0) begin fails++; $display("FAIL disp_106_idx got %h want 0", pixel_idx); end
        if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_106_valid got %b want 0", pixel_valid); end
        draw(99);
        checks++;
        if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_99_valid got %b want 0", pixel_valid); end
        draw(132);
        checks++;
        if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_132_valid got %b want 0", pixel_valid); end
        draw(100);
        checks++;
        if (pixel_idx !== pat(3232)) begin fails++; $display("FAIL disp_100_idx got %h want %h", pixel_idx, pat(3232)); end
        draw(131);
        checks++;
        if (pixel_idx !== pat(3263)) begin fails++; $display("FAIL disp_131_idx got %h want %h", pixel_idx, pat(3263)); end
    endtask

    task automatic test_miss();
        int n;
        int ys [2] = '{199, 232};
        foreach (ys[k]) begin
            pulse_line(ys[k]);
            tick();
            checks++;
            if (busy !== 1'b0) begin fails++; $display("FAIL miss_%0d_busy got %b want 0", ys[k], busy); end
            tick();
            checks++;
            if (rom_addr !== 15'd3263) begin fails++; $display("FAIL miss_%0d_rom_addr got %0d want 3263", ys[k], rom_addr); end
            pulse_line(300);
            tick();
            tick();
            count_valid(0, 1023, n);
            checks++;
            if (n !== 0) begin fails++; $display("FAIL miss_%0d_pixels got %0d want 0", ys[k], n); end
        end
    endtask

    task automatic test_check_restart();
        pulse_line(150);
        pulse_line(205);
        checks += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy got %b want 1", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL restart_overrun got %b want 0", overrun); end
        tick();
        checks++;
        if (rom_addr !== 15'd3232) begin fails++; $display("FAIL restart_rom_addr got %0d want 3232", rom_addr); end
        repeat (34) tick();
        checks += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL restart_busy_end got %b want 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL restart_overrun_end got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        int n;
        pulse_line(205);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL ovr_busy_mid got %b want 1", busy); end
        pulse_line(210);
        checks += 2;
        if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
        if (busy !== 1'b1) begin fails++; $display("FAIL ovr_busy_check got %b want 1", busy); end
        tick();
        checks++;
        if (rom_addr !== 15'd3392) begin fails++; $display("FAIL ovr_rom_addr got %0d want 3392", rom_addr); end
        repeat (34) tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ovr_busy_end got %b want 0", busy); end
        count_valid(0, 1023, n);
        checks++;
        if (n !== 0) begin fails++; $display("FAIL ovr_aborted_pixels got %0d want 0", n); end
        pulse_line(300);
        tick();
        tick();
        draw(100);
        checks++;
        if (pixel_idx !== pat(3392)) begin fails++; $display("FAIL ovr_row10_idx got %h want %h", pixel_idx, pat(3392)); end
        draw(105);
        checks += 2;
        if (pixel_idx !== pat(3397)) begin fails++; $display("FAIL ovr_row10_105 got %h want %h", pixel_idx, pat(3397)); end
        if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_clip();
        int nlo, nhi, exp_hi;
        exp_hi = 0;
        for (int k = 0; k < 14; k++) exp_hi += int'(pat(3232 + k) != 4'h0);
        set_desc(1010, 200, 3, 1'b1);
        pulse_line(205);
        repeat (35) tick();
        pulse_line(300);
        tick();
        tick();
        count_valid(0, 1009, nlo);
        count_valid(1010, 1023, nhi);
        checks += 2;
        if (nlo !== 0) begin fails++; $display("FAIL clip_low_pixels got %0d want 0", nlo); end
        if (nhi !== exp_hi) begin fails++; $display("FAIL clip_high_pixels got %0d want %0d", nhi, exp_hi); end
        draw(1023);
        checks++;
        if (pixel_idx !== pat(3245)) begin fails++; $display("FAIL clip_1023_idx got %h want %h", pixel_idx, pat(3245)); end
        draw(1015);
        checks++;
        if (pixel_idx !== 4'hA) begin fails++; $display("FAIL clip_1015_idx got %h want a", pixel_idx); end
    endtask

    task automatic test_reset_mid_fetch();
        set_desc(100, 200, 3, 1'b1);
        pulse_line(205);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        Reset_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
        if (rom_addr !== 15'd0) begin fails++; $display("FAIL rst_mid_rom_addr got %0d want 0", rom_addr); end
        if (pixel_idx !== 4'h0) begin fails++; $display("FAIL rst_mid_pixel_idx got %h want 0", pixel_idx); end
        if (pixel_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_pixel_valid got %b want 0", pixel_valid); end
        tick();
        Reset_n = 1'b1;
        tick();
        set_desc(100, 200, 3, 1'b1);
        pulse_line(205);
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (rom_addr !== 15'(3232 + i)) begin fails++; $display("FAIL rst_refetch_addr[%0d] got %0d want %0d", i, rom_addr, 3232 + i); end
        end
        tick();
        tick();
        pulse_line(300);
        tick();
        tick();
        draw(105);
        checks += 3;
        if (pixel_idx !== 4'hA) begin fails++; $display("FAIL rst_refetch_105_idx got %h want a", pixel_idx); end
        if (pixel_valid !== 1'b1) begin fails++; $display("FAIL rst_refetch_105_valid got %b want 1", pixel_valid); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL rst_refetch_overrun got %b want 0", overrun); end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) rom[a] = pat(a);
        test_reset();
        test_hit();
        test_display();
        test_miss();
        test_check_restart();
        test_overrun();
        test_clip();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sprite_line_fetch.md
SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

Interface
REQ-001 Parameter SPR_W, default 32: sprite width in pixels.
REQ-002 Parameter SPR_H, default 32: sprite height in lines.
REQ-003 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 frame_start  in  1  one-cycle pulse at vsync; latches the sprite descriptor.
REQ-006 line_start  in  1  one-cycle pulse at hblank start; requests a fetch for line Next_Y.
REQ-007 Next_Y  in  10  screen line to be displayed after the current one.
REQ-008 DrawX  in  10  current active-display pixel column.
REQ-009 Sprite_X, Sprite_Y  in  10 each  top-left sprite position from the animation controller.
REQ-010 Frame  in  5  sprite frame index from the animation controller.
REQ-011 Enable  in  1  sprite visible this video frame.
REQ-012 rom_addr  out  15  sprite ROM address, computed as Frame*1024 + row*SPR_W + col.
REQ-013 rom_data  in  4  palette index; synchronous ROM, valid 1 cycle after rom_addr.
REQ-014 pixel_idx  out  4  palette index for DrawX; 0 means transparent.
REQ-015 pixel_valid  out  1  pixel_idx is an opaque sprite pixel.
REQ-016 busy  out  1  high while in CHECK or FETCH.
REQ-017 overrun  out  1  sticky: a line_start arrived while FETCH was in progress.

Function
REQ-018 On frame_start the block SHALL latch Sprite_X, Sprite_Y, Frame and Enable into descriptor registers; the inputs are ignored at all other times.
REQ-019 The state machine SHALL have states IDLE, CHECK, FETCH and DRAIN.
REQ-020 IDLE -> CHECK on line_start; both line buffers SHALL swap (fetch <-> display) on the same edge.
REQ-021 CHECK (1 cycle): row = Next_Y - Y_lat, computed in 11 bits. The line is a hit when Enable_lat=1, Next_Y >= Y_lat and row < SPR_H. Hit -> FETCH with col=0; miss -> clear the fetch-buffer valid flag and return to IDLE.
REQ-022 FETCH SHALL issue one rom_addr per cycle for col 0..SPR_W-1 (SPR_W cycles). On each cycle, rom_data for the previous address SHALL be written to fetch_buf[col-1].
REQ-023 DRAIN (1 cycle) SHALL write the last entry, set the fetch-buffer valid flag and return to IDLE. Total hit latency from line_start to fetch complete is SPR_W+2 cycles.
REQ-024 A line_start during FETCH or DRAIN SHALL abort the fetch, set overrun, leave the fetch-buffer valid flag cleared, swap buffers and enter CHECK.
REQ-025 A line_start during CHECK SHALL restart CHECK with the new Next_Y; overrun is not set in this case.
REQ-026 A frame_start coinciding with line_start SHALL latch the descriptor first, so the CHECK in that cycle uses the new descriptor.
REQ-027 Output, registered with 1-cycle latency from DrawX: dx = DrawX - X_lat in 11 bits. When the display buffer is valid, DrawX >= X_lat and dx < SPR_W, pixel_idx SHALL be disp_buf[dx]; otherwise pixel_idx = 0.
REQ-028 pixel_valid SHALL be 1 exactly when the registered pixel_idx is nonzero.
REQ-029 A sprite extending past column 1023 or line 1023 SHALL be clipped; it SHALL NOT wrap to column 0 or line 0.
REQ-030 rom_addr SHALL hold its last value outside FETCH.
REQ-031 overrun SHALL clear only on reset.

Reset
REQ-032 Reset_n low SHALL, immediately and asynchronously, force:
- state = IDLE;
- busy, overrun, pixel_valid = 0;
- pixel_idx, rom_addr = 0;
- descriptor registers = 0;
- both buffer valid flags = 0.
Buffer contents are don't-care.
REQ-033 Reset asserted mid-FETCH SHALL discard the partial line; the first line_start after release SHALL behave as from IDLE.

Structure
REQ-034 A shared package SHALL hold SPR_W, SPR_H, the ROM address width (15), the palette-index width (4) and the fetch state enum.
REQ-035 One sub-module, sprite_line_buf, SHALL implement the two SPR_W x 4 line buffers, the swap select and the valid flags.

Verification
REQ-036 Hit line: descriptor X=100, Y=200, Frame=3; line_start with Next_Y=205 -> rom_addr runs 3232..3263, busy high for 33 cycles.
REQ-037 Miss lines: Next_Y=199 and Next_Y=232 with Y_lat=200 -> no FETCH, and pixel_valid stays 0 for that whole line.
REQ-038 Display: ROM pixel at col 5 = 0xA, col 6 = 0 -> one cycle after DrawX=105, pixel_idx=0xA and pixel_valid=1; after DrawX=106, pixel_valid=0; after DrawX=99 or DrawX=132, pixel_valid=0.
REQ-039 Overrun: second line_start 10 cycles into a FETCH -> overrun=1, new CHECK starts, and the aborted line shows no pixels.
REQ-040 Clip: X_lat=1010 -> pixels only for DrawX 1010..1023, none at DrawX 0..17.
REQ-041 Reset: Reset_n pulsed low mid-FETCH -> outputs 0 immediately; the next hit line fetches normally.
